// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video text fetches win by default, a bounded
// wait counter forces the CPU through, and a tag pipeline steers read data back.
module vram_arbiter #(
  parameter int data_width = 8,
  parameter int addr_width = 10,
  parameter int max_wait   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vid_req,
  input  logic [addr_width-1:0] vid_addr,
  output logic                  vid_valid,
  output logic [data_width-1:0] vid_data,
  output logic                  vid_ovr,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [addr_width-1:0] cpu_addr,
  input  logic [data_width-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [data_width-1:0] cpu_rdata,
  output logic [addr_width-1:0] ram_address,
  output logic [data_width-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [data_width-1:0] ram_q
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_VID  = 2'd1,
    TAG_CRD  = 2'd2,
    TAG_CWR  = 2'd3
  } tag_t;

  localparam logic [3:0] WAIT_MAX = 4'(max_wait);

  function automatic logic [3:0] wait_inc(input logic [3:0] cnt);
    return (cnt >= WAIT_MAX) ? WAIT_MAX : cnt + 4'd1;
  endfunction

  logic                  vid_pend_q, vid_pend_d;
  logic [addr_width-1:0] vid_addr_q, vid_addr_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  tag_t                  tag_p1_q, tag_p1_d, tag_p2_q;
  logic [addr_width-1:0] ram_address_q, ram_address_d;
  logic [data_width-1:0] ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;
  logic [data_width-1:0] vid_data_q, cpu_rdata_q;

  logic cpu_busy, cpu_elig, vid_any, gnt_cpu, gnt_vid;

  // Grant stage: CPU is ineligible while its access is in flight or being acked.
  always_comb begin
    cpu_busy = (tag_p1_q == TAG_CRD) || (tag_p1_q == TAG_CWR) || (tag_p2_q == TAG_CRD);
    cpu_elig = cpu_req && !cpu_busy;
    vid_any  = vid_pend_q || vid_req;
    gnt_cpu  = 1'b0;
    gnt_vid  = 1'b0;
    if (cpu_elig && (wait_cnt_q == WAIT_MAX)) begin
      gnt_cpu = 1'b1;
    end else if (vid_any) begin
      gnt_vid = 1'b1;
    end else if (cpu_elig) begin
      gnt_cpu = 1'b1;
    end
  end

  // A fresh strobe with nothing pending is served directly when video wins.
  always_comb begin
    vid_addr_d = vid_req ? vid_addr : vid_addr_q;
    if (vid_req) begin
      vid_pend_d = !(gnt_vid && !vid_pend_q);
    end else begin
      vid_pend_d = vid_pend_q && !gnt_vid;
    end
    vid_ovr = vid_req && vid_pend_q && !gnt_vid;

    if (!cpu_req || gnt_cpu) begin
      wait_cnt_d = 4'd0;
    end else if (cpu_elig) begin
      wait_cnt_d = wait_inc(wait_cnt_q);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  always_comb begin
    tag_p1_d      = TAG_NONE;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    if (gnt_vid) begin
      tag_p1_d      = TAG_VID;
      ram_address_d = vid_pend_q ? vid_addr_q : vid_addr;
    end else if (gnt_cpu) begin
      tag_p1_d      = cpu_we ? TAG_CWR : TAG_CRD;
      ram_address_d = cpu_addr;
      ram_data_d    = cpu_wdata;
      ram_wren_d    = cpu_we;
    end
  end

  // Return stage: writes complete with the RAM strobe, reads one cycle later.
  always_comb begin
    vid_valid = (tag_p2_q == TAG_VID);
    vid_data  = vid_valid ? ram_q : vid_data_q;
    cpu_ack   = (tag_p1_q == TAG_CWR) || (tag_p2_q == TAG_CRD);
    cpu_rdata = (tag_p2_q == TAG_CRD) ? ram_q : cpu_rdata_q;
  end

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      vid_pend_q    <= 1'b0;
      wait_cnt_q    <= 4'd0;
      tag_p1_q      <= TAG_NONE;
      tag_p2_q      <= TAG_NONE;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      vid_data_q    <= '0;
      cpu_rdata_q   <= '0;
    end else begin
      vid_pend_q    <= vid_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      tag_p1_q      <= tag_p1_d;
      tag_p2_q      <= tag_p1_q;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      vid_data_q    <= vid_data;
      cpu_rdata_q   <= cpu_rdata;
    end
  end

  always_ff @(posedge clock) begin
    vid_addr_q <= vid_addr_d;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural one-cycle-latency RAM.
module tb_vram_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       vid_req;
  logic [9:0] vid_addr;
  logic       vid_valid;
  logic [7:0] vid_data;
  logic       vid_ovr;
  logic       cpu_req;
  logic       cpu_we;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [9:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_q;

  logic [7:0] mem [1024];
  int n_chk = 0;
  int n_pass = 0;

  vram_arbiter #(.data_width(8), .addr_width(10), .max_wait(4)) dut (
    .clock(clock), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid),
    .vid_data(vid_data), .vid_ovr(vid_ovr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [9:0]  exp_ra [17];
  logic [16:0] vv_mask;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h010] = 8'h11;
    mem[10'h020] = 8'h22;
    mem[10'h001] = 8'hC1;
    mem[10'h002] = 8'hC2;
    mem[10'h10C] = 8'h7E;
    exp_ra = '{10'h020, 10'h100, 10'h101, 10'h102, 10'h103, 10'h020, 10'h104,
               10'h105, 10'h106, 10'h107, 10'h108, 10'h109, 10'h020, 10'h002,
               10'h10C, 10'h10C, 10'h10C};
    vv_mask = 17'b0_1101_1111_1011_1100;

    reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    smp();
    chk("rst_vid_valid", 32'(vid_valid), 32'h0);
    chk("rst_vid_data", 32'(vid_data), 32'h0);
    chk("rst_vid_ovr", 32'(vid_ovr), 32'h0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_ram_address", 32'(ram_address), 32'h0);
    chk("rst_ram_data", 32'(ram_data), 32'h0);
    chk("rst_ram_wren", 32'(ram_wren), 32'h0);
    nxt();

    // CPU write 0x5A to 0x3FF
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'h5A;
    smp();
    chk("wr_grant_ack", 32'(cpu_ack), 32'h0);
    chk("wr_grant_wren", 32'(ram_wren), 32'h0);
    nxt();
    smp();
    chk("wr_wren", 32'(ram_wren), 32'h1);
    chk("wr_addr", 32'(ram_address), 32'h3FF);
    chk("wr_data", 32'(ram_data), 32'h5A);
    chk("wr_ack", 32'(cpu_ack), 32'h1);
    nxt();
    cpu_req = 1'b0; cpu_we = 1'b0;
    smp();
    chk("wr_wren_off", 32'(ram_wren), 32'h0);
    chk("wr_ack_off", 32'(cpu_ack), 32'h0);
    nxt();

    // CPU read 0x3FF, request held through the ack
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    smp();
    nxt();
    smp();
    chk("rd_addr", 32'(ram_address), 32'h3FF);
    chk("rd_wren", 32'(ram_wren), 32'h0);
    chk("rd_ack_early", 32'(cpu_ack), 32'h0);
    nxt();
    smp();
    chk("rd_ack", 32'(cpu_ack), 32'h1);
    chk("rd_rdata", 32'(cpu_rdata), 32'h5A);
    nxt();
    smp();
    chk("held_ack_c1", 32'(cpu_ack), 32'h0);
    nxt();
    smp();
    chk("held_ack_c2", 32'(cpu_ack), 32'h0);
    nxt();
    cpu_req = 1'b0;
    smp();
    chk("held_ack", 32'(cpu_ack), 32'h1);
    chk("held_rdata", 32'(cpu_rdata), 32'h5A);
    nxt();
    smp();
    chk("held_ack_after", 32'(cpu_ack), 32'h0);
    nxt();

    // Simultaneous video 0x010 and CPU read 0x020
    vid_req = 1'b1; vid_addr = 10'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
    smp();
    chk("sim_ovr", 32'(vid_ovr), 32'h0);
    nxt();
    vid_req = 1'b0;
    smp();
    chk("sim_vid_first", 32'(ram_address), 32'h010);
    nxt();
    smp();
    chk("sim_cpu_second", 32'(ram_address), 32'h020);
    chk("sim_vid_valid", 32'(vid_valid), 32'h1);
    chk("sim_vid_data", 32'(vid_data), 32'h11);
    chk("sim_cpu_ack_early", 32'(cpu_ack), 32'h0);
    nxt();
    smp();
    chk("sim_cpu_ack", 32'(cpu_ack), 32'h1);
    chk("sim_cpu_rdata", 32'(cpu_rdata), 32'h22);
    chk("sim_vid_valid_off", 32'(vid_valid), 32'h0);
    chk("sim_vid_data_hold", 32'(vid_data), 32'h11);
    nxt();
    cpu_req = 1'b0;
    smp();
    nxt();

    // Starvation bound and overrun: video every cycle, CPU read held
    for (int k = 0; k <= 16; k++) begin
      vid_req = (k <= 12);
      if (k == 10) vid_addr = 10'h001;
      else if (k == 11) vid_addr = 10'h002;
      else vid_addr = 10'(32'h100 + k);
      cpu_req = (k <= 13); cpu_we = 1'b0; cpu_addr = 10'h020;
      smp();
      chk($sformatf("stv_ovr_k%0d", k), 32'(vid_ovr), 32'(k == 11));
      chk($sformatf("stv_ack_k%0d", k), 32'(cpu_ack), 32'(k == 6 || k == 13));
      chk($sformatf("stv_addr_k%0d", k), 32'(ram_address), 32'(exp_ra[k]));
      chk($sformatf("stv_vvalid_k%0d", k), 32'(vid_valid), 32'(vv_mask[k]));
      if (k == 6 || k == 13) chk($sformatf("stv_rdata_k%0d", k), 32'(cpu_rdata), 32'h22);
      if (k == 14) chk("ovr_new_data", 32'(vid_data), 32'hC2);
      if (k == 15) chk("ovr_next_data", 32'(vid_data), 32'h7E);
      nxt();
    end

    // Reset in the cycle after a CPU read grant drops the read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    smp();
    nxt();
    reset = 1'b1; cpu_req = 1'b0;
    smp();
    chk("rstf_ack_r1", 32'(cpu_ack), 32'h0);
    nxt();
    reset = 1'b0;
    smp();
    chk("rstf_ack_r2", 32'(cpu_ack), 32'h0);
    chk("rstf_vid_valid", 32'(vid_valid), 32'h0);
    chk("rstf_ram_address", 32'(ram_address), 32'h0);
    chk("rstf_ram_wren", 32'(ram_wren), 32'h0);
    chk("rstf_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("rstf_vid_data", 32'(vid_data), 32'h0);
    nxt();
    smp();
    chk("rstf_ack_r3", 32'(cpu_ack), 32'h0);
    nxt();
    smp();
    chk("rstf_ack_r4", 32'(cpu_ack), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
